// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Single-outstanding APB initiator bridging a valid/ready
//               request/response port to APB SETUP/ACCESS transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic        c_wdog_en    = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] c_wdog_limit = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_wdog;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state       <= ST_IDLE;
            r_wdog        <= 16'd0;
            PADDR         <= '0;
            PWDATA        <= 32'd0;
            PWRITE        <= 1'b0;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= 32'd0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        PADDR       <= req_addr_i;
                        PWDATA      <= req_wdata_i;
                        PWRITE      <= req_write_i;
                        PSEL        <= 1'b1;
                        PENABLE     <= 1'b0;
                        req_ready_o <= 1'b0;
                        r_state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    r_wdog  <= 16'd0;
                    r_state <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // PREADY is checked first so it wins over a same-cycle timeout.
                    if (PREADY) begin
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= PWRITE ? 32'd0 : PRDATA;
                        rsp_err_o     <= PSLVERR;
                        rsp_timeout_o <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (c_wdog_en && (r_wdog == c_wdog_limit)) begin
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= 32'd0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (r_wdog != 16'hFFFF) begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge with an APB slave
//               model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int AW  = 12;
    localparam int TMO = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid_i, req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          req_write_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o, rsp_timeout_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE, PSEL, PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transfer; the slave holds PREADY low for 'waits' ACCESS cycles.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input logic se,
                           input int rsp_delay);
        int          cyc, acc, guard;
        logic [31:0] e_rdata;
        logic        e_err, e_to;
        int          e_acc, e_lat;

        if (waits >= TMO) begin
            e_rdata = 32'd0; e_err = 1'b1; e_to = 1'b1; e_acc = TMO;
        end else begin
            e_rdata = wr ? 32'd0 : rd; e_err = se; e_to = 1'b0; e_acc = waits + 1;
        end
        e_lat = e_acc + 2;

        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_addr_i = addr; req_wdata_i = wd; req_write_i = wr;
        @(posedge HCLK); #1;
        req_valid_i = 1'b0;
        req_addr_i  = AW'($urandom);
        req_wdata_i = $urandom;
        req_write_i = 1'($urandom);
        cyc = 1; acc = 0;
        chk("setup_sel_en", {30'd0, PSEL, PENABLE}, 32'd2);
        chk("setup_paddr",  {20'd0, PADDR}, {20'd0, addr});
        chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, wr});
        chk("setup_pwdata", PWDATA, wd);
        chk("setup_req_rdy", {31'd0, req_ready_o}, 32'd0);

        guard = 0;
        while (guard < 40) begin
            @(posedge HCLK); #1;
            cyc++; guard++;
            PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
            if (!(PSEL && PENABLE)) break;
            acc++;
            if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd)
                chk("access_stable", {20'd0, PADDR}, {20'd0, addr});
            if (req_ready_o !== 1'b0)
                chk("access_req_rdy", {31'd0, req_ready_o}, 32'd0);
            if (acc > waits) begin
                PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
            end
        end
        chk("xfer_bounded", {31'd0, guard < 40}, 32'd1);
        chk("access_cycles", acc, e_acc);
        chk("rsp_latency",   cyc, e_lat);
        chk("rsp_valid",     {31'd0, rsp_valid_o}, 32'd1);
        chk("rsp_sel_en",    {30'd0, PSEL, PENABLE}, 32'd0);
        chk("rsp_rdata",     rsp_rdata_o, e_rdata);
        chk("rsp_err",       {31'd0, rsp_err_o}, {31'd0, e_err});
        chk("rsp_timeout",   {31'd0, rsp_timeout_o}, {31'd0, e_to});

        // A stray late PREADY while the response is held must change nothing.
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        rsp_ready_i = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            @(posedge HCLK); #1;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e_rdata || rsp_err_o !== e_err ||
                rsp_timeout_o !== e_to || req_ready_o !== 1'b0 || PSEL !== 1'b0)
                chk("rsp_hold", {27'd0, rsp_valid_o, rsp_err_o, rsp_timeout_o, req_ready_o, PSEL},
                    {27'd0, 1'b1, e_err, e_to, 1'b0, 1'b0});
        end
        rsp_ready_i = 1'b1;
        @(posedge HCLK); #1;
        rsp_ready_i = 1'b0;
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("rsp_done_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rsp_done_ready", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int guard;
        logic          r_wr, r_se;
        logic [AW-1:0] r_addr;
        logic [31:0]   r_wd, r_rd;

        HRESET = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_wdata_i = 32'd0; req_write_i = 1'b0;
        rsp_ready_i = 1'b0; PRDATA = 32'd0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_sel_en",    {30'd0, PSEL, PENABLE}, 32'd0);
        chk("rst_pwrite",    {31'd0, PWRITE}, 32'd0);
        chk("rst_paddr",     {20'd0, PADDR}, 32'd0);
        chk("rst_pwdata",    PWDATA, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_rsp",       {29'd0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 32'd0);
        chk("rst_rdata",     rsp_rdata_o, 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        do_xfer(1'b1, 12'h004, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0, 0);
        do_xfer(1'b0, 12'h010, 32'h0,        2, 32'h12345678, 1'b0, 0);
        do_xfer(1'b0, 12'h020, 32'h0,        0, 32'hCAFEF00D, 1'b1, 0);
        do_xfer(1'b0, 12'h030, 32'h0,       10, 32'h87654321, 1'b0, 2);
        do_xfer(1'b0, 12'h034, 32'h0,        3, 32'h0BADCAFE, 1'b0, 0);
        do_xfer(1'b1, 12'h040, 32'h11223344, 0, 32'h0,        1'b0, 10);
        do_xfer(1'b1, 12'h044, 32'h55667788, 0, 32'h0,        1'b0, 0);

        // Reset pulse in the second wait state of a read.
        req_valid_i = 1'b1; req_addr_i = 12'h050; req_write_i = 1'b0; req_wdata_i = 32'h0;
        @(posedge HCLK); #1;
        req_valid_i = 1'b0;
        guard = 0;
        while (guard < 3) begin
            @(posedge HCLK); #1;
            if (PSEL && PENABLE) guard++;
            else if (!PSEL) break;
        end
        chk("rst_mid_reached", guard, 3);
        #2 HRESET = 1'b1;
        #1;
        chk("rst_async_sel_en", {30'd0, PSEL, PENABLE}, 32'd0);
        chk("rst_async_rsp",    {31'd0, rsp_valid_o}, 32'd0);
        PREADY = 1'b1; PRDATA = 32'hFFFFFFFF;
        @(posedge HCLK); #1;
        HRESET = 1'b0; PREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge HCLK); #1;
            if (rsp_valid_o !== 1'b0 || PSEL !== 1'b0)
                chk("post_rst_quiet", {30'd0, rsp_valid_o, PSEL}, 32'd0);
        end
        do_xfer(1'b1, 12'h058, 32'h0F0F0F0F, 0, 32'h0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            r_wr   = 1'($urandom);
            r_addr = AW'($urandom);
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_se   = ($urandom_range(0, 3) == 0);
            do_xfer(r_wr, r_addr, r_wd, $urandom_range(0, 6), r_rd, r_se, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge HCLK); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
